// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit two-flop synchronizer and saturating stability counter debouncer
module switch_debouncer #(
    parameter int WIDTH         = 18,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    input  logic             freeze,
    output logic [WIDTH-1:0] switches,
    output logic             changed,
    output logic [WIDTH-1:0] change_mask
);

    // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit for the 1-cycle case.
    localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    count [WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            switches    <= '0;
            change_mask <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1       <= switches_raw;
            sync2       <= sync1;
            change_mask <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (freeze || (sync2[i] == switches[i])) begin
                    count[i] <= '0;
                end else if (count[i] == LAST) begin
                    switches[i]    <= sync2[i];
                    change_mask[i] <= 1'b1;
                    count[i]       <= '0;
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
        end
    end

    // A single pulse covers every bit that updated on the same edge.
    assign changed = |change_mask;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer with STABLE_CYCLES=4
module tb_switch_debouncer;

    localparam int W = 18;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] switches_raw;
    logic         freeze;
    logic [W-1:0] switches;
    logic         changed;
    logic [W-1:0] change_mask;

    switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .switches_raw (switches_raw),
        .freeze       (freeze),
        .switches     (switches),
        .changed      (changed),
        .change_mask  (change_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        int           edge_no;
        logic [W-1:0] mask;
        logic [W-1:0] sw;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    bit   done = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void push_exp(int e, logic [W-1:0] m, logic [W-1:0] s);
        exp_t x;
        x.edge_no = e;
        x.mask    = m;
        x.sw      = s;
        q.push_back(x);
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got 0x%05h, expected 0x%05h", name, cyc, act, req);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!done) begin
            if (changed) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_pulse at edge %0d: mask 0x%05h, expected no pulse", cyc, change_mask);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("pulse_edge", W'(cyc), W'(x.edge_no));
                    check("change_mask", change_mask, x.mask);
                    check("switches", switches, x.sw);
                end
            end else if (q.size() > 0 && q[0].edge_no < cyc) begin
                exp_t x;
                x = q.pop_front();
                vectors++;
                errors++;
                $display("FAIL missed_pulse: got none by edge %0d, expected mask 0x%05h at edge %0d", cyc, x.mask, x.edge_no);
            end
        end
    end

    initial begin
        int k;
        reset        = 1'b1;
        freeze       = 1'b0;
        switches_raw = 18'h3FFFF;
        step(3);
        check("reset_switches", switches, '0);
        check("reset_mask", change_mask, '0);
        check("reset_changed", W'(changed), '0);

        // All bits rise together out of reset.
        reset = 1'b0;
        k = cyc + 1;
        push_exp(k + 5, 18'h3FFFF, 18'h3FFFF);
        step(5);
        check("hold_until_k4", switches, '0);
        step(5);

        // All bits fall together.
        switches_raw = '0;
        k = cyc + 1;
        push_exp(k + 5, 18'h3FFFF, 18'h00000);
        step(8);

        // Three-cycle bounce on bit0: no update, no pulse.
        switches_raw = 18'h00001;
        step(3);
        switches_raw = '0;
        step(10);
        check("bounce_bit0", switches, '0);

        // Single bit5 rise.
        switches_raw = 18'h00020;
        k = cyc + 1;
        push_exp(k + 5, 18'h00020, 18'h00020);
        step(8);

        // Staggered bit1 and bit2 give two separate pulses.
        switches_raw = 18'h00022;
        k = cyc + 1;
        push_exp(k + 5, 18'h00002, 18'h00022);
        push_exp(k + 7, 18'h00004, 18'h00026);
        step(2);
        switches_raw = 18'h00026;
        step(8);

        // Freeze for 10 edges starting at k+3; update lands at f+3.
        switches_raw = 18'h0002E;
        k = cyc + 1;
        push_exp(k + 16, 18'h00008, 18'h0002E);
        step(3);
        freeze = 1'b1;
        step(9);
        check("freeze_hold", switches, 18'h00026);
        step(1);
        freeze = 1'b0;
        step(8);

        // Reset at k+3 interrupts bit7; everything re-counts from the first post-reset edge.
        switches_raw = 18'h000AE;
        k = cyc + 1;
        step(3);
        reset = 1'b1;
        step(1);
        check("reset_mid_switches", switches, '0);
        step(1);
        reset = 1'b0;
        push_exp(cyc + 1 + 5, 18'h000AE, 18'h000AE);
        step(4);
        check("post_reset_hold", switches, '0);
        step(8);

        done = 1;
        check("queue_drained", W'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 18, is the number of switch bits conditioned.
REQ-002 Parameter STABLE_CYCLES, default 50000, is the number of consecutive cycles a synchronized input must differ from the output before the output updates; legal range 1..2^20.
REQ-003 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port switches_raw, input, WIDTH bits: asynchronous board switch levels.
REQ-006 Port freeze, input, 1 bit: while high, holds the output and clears all debounce counters.
REQ-007 Port switches, output, WIDTH bits: debounced level, drives the CPU switch input directly.
REQ-008 Port changed, output, 1 bit: one-cycle pulse when any bit of switches updates.
REQ-009 Port change_mask, output, WIDTH bits: bits of switches that updated this cycle; zero otherwise.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer, sync1 then sync2, before any comparison; sync2 is the only value compared.
REQ-011 Each bit SHALL own an independent counter, no wider than 20 bits, that saturates at STABLE_CYCLES-1.
REQ-012 At each edge with freeze low, if sync2[i] equals switches[i], counter[i] SHALL clear to 0.
REQ-013 At each edge with freeze low, if sync2[i] differs and counter[i] < STABLE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-014 At each edge with freeze low, if sync2[i] differs and counter[i] == STABLE_CYCLES-1, switches[i] SHALL take sync2[i] and counter[i] SHALL clear to 0.
REQ-015 Latency: when switches_raw changes before edge k and stays constant, switches SHALL update at edge k+STABLE_CYCLES+1.
REQ-016 A bounce, meaning sync2 returns to equal switches before the count completes, SHALL clear the counter; no output change and no pulse SHALL result.
REQ-017 change_mask SHALL be registered; at the edge where switches[i] updates, change_mask[i] SHALL be 1, and at every other edge 0.
REQ-018 changed SHALL equal the OR-reduction of the registered change_mask and SHALL therefore be high for exactly one cycle per update edge.
REQ-019 When several bits update at the same edge, they SHALL produce a single pulse with all updated bits set in change_mask.
REQ-020 While freeze is high, switches SHALL hold, all counters SHALL be 0, and changed/change_mask SHALL be 0; the synchronizer keeps sampling.
REQ-021 When freeze falls, counting SHALL resume at the first edge where freeze is low; that edge counts as the first increment.
REQ-022 With freeze low again, a bit that still differs SHALL update at edge f+STABLE_CYCLES-1, where f is that first edge.
REQ-023 When STABLE_CYCLES == 1, a bit SHALL update at the first edge where sync2 differs.

Reset
REQ-024 At an edge with reset high, sync1, sync2, switches, all counters, change_mask and changed SHALL all be 0.
REQ-025 reset SHALL override freeze and any in-progress count; a count interrupted by reset SHALL restart from 0.
REQ-026 During reset, switches SHALL remain 0 regardless of switches_raw.

Verification (STABLE_CYCLES=4, WIDTH=18)
REQ-027 Scenario: reset high while switches_raw=0x3FFFF, then release; let k be the first edge after release -> switches=0 through edge k+4; at edge k+5, switches=0x3FFFF, changed=1 and change_mask=0x3FFFF for one cycle.
REQ-028 Scenario: with bit0 settled at 0, pulse raw bit0 to 1 for 3 cycles, then back to 0 -> switches[0] stays 0 and changed never asserts.
REQ-029 Scenario: raise raw bit5 before edge k -> switches=0x00020 at edge k+5; change_mask=0x00020 for one cycle, then 0.
REQ-030 Scenario: raise raw bit1 before edge k and raw bit2 before edge k+2 -> two separate pulses, at k+5 (mask 0x00002) and at k+7 (mask 0x00004).
REQ-031 Scenario: raise raw bit3 and assert freeze for 10 cycles starting at edge k+3; let f be the first edge with freeze low -> no update while freeze is high; switches[3]=1 at edge f+3.
REQ-032 Scenario: raise raw bit7, then assert reset at edge k+3 and release it -> switches stays 0 through reset; the count restarts and the update occurs 5 edges after the first post-reset edge.
